datamem_responder: RTL and testbench

Responder end of the core's data-memory interface: accepts one load/store request at a time over a valid/ready handshake, performs the access after a configurable number of wait states, and returns a response over a second valid/ready handshake. It replaces the single-cycle combinational data memory when the core moves to a multi-cycle/stalling memory path. It decodes RISC-V funct3 sizes itself, and applies sign/zero extension and byte-lane placement itself.

---
 rtl/datamem_responder_if.sv | 24 ++
 rtl/datamem_responder.sv | 194 +++++++++++++++++++
 tb/tb_datamem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/datamem_responder_if.sv
// Request/response bus between the core's load/store unit (master) and the
// data-memory responder (slave): one valid/ready handshake in each direction.
interface datamem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/datamem_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_STATES wait cycles, held response.
// Optional DMEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into error responses.
module datamem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic               clk,
    input logic               rst,
    datamem_responder_if.slave bus
);
    localparam int unsigned CW    = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic                  a_write;
    logic [31:0]           a_addr;
    logic [31:0]           a_wdata;
    logic [2:0]            a_f3;
    logic                  f3_ok;
    logic                  misaligned;
    logic                  illegal;
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [31:0]           load_data;
    logic [31:0]           wr_lanes;
    logic [3:0]            wr_mask;
    logic                  commit;
    logic                  mem_we;
    logic                  unused_addr_bits;

    // In IDLE the access path looks at the live request so zero-wait builds can commit at acceptance.
    always_comb begin
        if (state_q == S_IDLE) begin
            a_write = bus.req_write;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
            a_f3    = bus.req_funct3;
        end else begin
            a_write = wr_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
            a_f3    = f3_q;
        end
    end

    always_comb begin
        if (a_write) begin
            f3_ok = (a_f3 == 3'b000) || (a_f3 == 3'b001) || (a_f3 == 3'b010);
        end else begin
            f3_ok = (a_f3 != 3'b011) && (a_f3 != 3'b110) && (a_f3 != 3'b111);
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        misaligned = ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
                     ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        illegal = !f3_ok || misaligned;
        // Misaligned halves/words snap down to their natural boundary.
        off = a_addr[1:0];
        if (a_f3[1:0] == 2'b01) begin
            off[0] = 1'b0;
        end else if (a_f3[1:0] == 2'b10) begin
            off = 2'b00;
        end
    end

    assign widx             = a_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^a_addr[31:ADDR_WIDTH+2];
    assign rd_word          = mem_q[widx];
    assign rd_shift         = rd_word >> {off, 3'b000};

    always_comb begin
        case (a_f3)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_data = {24'h0, rd_shift[7:0]};
            3'b101:  load_data = {16'h0, rd_shift[15:0]};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        case (a_f3[1:0])
            2'b00: begin
                wr_mask  = 4'b0001 << off;
                wr_lanes = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                wr_mask  = 4'b0011 << off;
                wr_lanes = {2{a_wdata[15:0]}};
            end
            default: begin
                wr_mask  = 4'b1111;
                wr_lanes = a_wdata;
            end
        endcase
    end

    assign commit = !illegal &&
                    (((state_q == S_IDLE) && bus.req_valid && req_ready_q && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == CW'(1))));
    assign mem_we = commit && a_write && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem_q[widx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        wr_q        <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        f3_q        <= bus.req_funct3;
                        req_ready_q <= 1'b0;
                        if (illegal) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (WAIT_STATES == 0) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= a_write ? '0 : load_data;
                        end else begin
                            cnt_q   <= CW'(WAIT_STATES);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= wr_q ? '0 : load_data;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_datamem_responder.sv
// Directed bench for datamem_responder: a WAIT_STATES=2 instance and a zero-wait instance
// share one stimulus driver; sel chooses which one receives requests and is observed.
module tb_datamem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    datamem_responder_if ifa ();
    datamem_responder_if ifz ();

    datamem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    datamem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_z (.clk(clk), .rst(rst), .bus(ifz));

    logic        sel;
    logic        t_valid, t_write, t_rready;
    logic [31:0] t_addr, t_wdata;
    logic [2:0]  t_f3;

    assign ifa.req_valid  = t_valid && !sel;
    assign ifz.req_valid  = t_valid && sel;
    assign ifa.req_write  = t_write;
    assign ifz.req_write  = t_write;
    assign ifa.req_addr   = t_addr;
    assign ifz.req_addr   = t_addr;
    assign ifa.req_wdata  = t_wdata;
    assign ifz.req_wdata  = t_wdata;
    assign ifa.req_funct3 = t_f3;
    assign ifz.req_funct3 = t_f3;
    assign ifa.rsp_ready  = t_rready;
    assign ifz.rsp_ready  = t_rready;

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;
    assign o_ready = sel ? ifz.req_ready : ifa.req_ready;
    assign o_valid = sel ? ifz.rsp_valid : ifa.rsp_valid;
    assign o_err   = sel ? ifz.rsp_err   : ifa.rsp_err;
    assign o_rdata = sel ? ifz.rsp_rdata : ifa.rsp_rdata;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          hold;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic s, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f,
                                input logic [31:0] er, input logic ee, input int el, input int h);
        vec_t v;
        v.sel = s; v.wr = w; v.addr = a; v.wdata = d; v.f3 = f;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.hold = h;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_idle"}, 64'(o_ready), 64'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    lat;
        string nm;
        nm  = $sformatf("v%0d", idx);
        sel = v.sel;
        #1;
        wait_idle(nm);
        t_valid = 1'b1; t_write = v.wr; t_addr = v.addr; t_wdata = v.wdata; t_f3 = v.f3;
        @(posedge clk); #1;
        t_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_lat"},   64'(lat),     64'(v.exp_lat));
        check({nm, "_rdata"}, 64'(o_rdata), 64'(v.exp_rdata));
        check({nm, "_err"},   64'(o_err),   64'(v.exp_err));
        // Backpressure: offer a conflicting store that must be ignored while the response is held.
        for (int i = 0; i < v.hold; i++) begin
            t_valid = 1'b1; t_write = 1'b1; t_addr = 32'h10; t_wdata = 32'hBAD0BAD0; t_f3 = 3'd2;
            @(posedge clk); #1;
            check($sformatf("%s_hold%0d", nm, i), {29'b0, o_valid, o_ready, o_err, o_rdata},
                  {29'b0, 1'b1, 1'b0, v.exp_err, v.exp_rdata});
        end
        t_valid  = 1'b0;
        t_rready = 1'b1;
        @(posedge clk); #1;
        t_rready = 1'b0;
        check({nm, "_post"}, {62'b0, o_valid, o_ready}, {62'b0, 1'b0, 1'b1});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; t_valid = 1'b0; t_write = 1'b0; t_rready = 1'b0;
        t_addr = '0; t_wdata = '0; t_f3 = '0;

        // sel, wr, addr, wdata, f3, exp_rdata, exp_err, exp_lat, hold
        vecs.push_back(mk(0, 1, 32'h10,   32'hDEADBEEF, 3'd2, 32'h0,        0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h10,   32'h0,        3'd2, 32'hDEADBEEF, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h10,   32'h0,        3'd2, 32'hDEADBEEF, 0, 3, 5));
        vecs.push_back(mk(0, 0, 32'h10,   32'h0,        3'd2, 32'hDEADBEEF, 0, 3, 0));
        vecs.push_back(mk(0, 1, 32'h20,   32'h11223344, 3'd2, 32'h0,        0, 3, 0));
        vecs.push_back(mk(0, 1, 32'h21,   32'h123456AA, 3'd0, 32'h0,        0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h20,   32'h0,        3'd2, 32'h1122AA44, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h21,   32'h0,        3'd0, 32'hFFFFFFAA, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h21,   32'h0,        3'd4, 32'h000000AA, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h22,   32'h0,        3'd1, 32'h00001122, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h20,   32'h0,        3'd5, 32'h0000AA44, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h20,   32'h0,        3'd1, 32'hFFFFAA44, 0, 3, 0));
        vecs.push_back(mk(0, 1, 32'h22,   32'hBEEF8001, 3'd1, 32'h0,        0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h20,   32'h0,        3'd2, 32'h8001AA44, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h23,   32'h0,        3'd0, 32'hFFFFFF80, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h20,   32'h0,        3'd3, 32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h20,   32'h0,        3'd6, 32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h20,   32'h0,        3'd7, 32'h0,        1, 1, 2));
        vecs.push_back(mk(0, 1, 32'h20,   32'hFFFFFFFF, 3'd3, 32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h20,   32'hFFFFFFFF, 3'd4, 32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h20,   32'hFFFFFFFF, 3'd5, 32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h20,   32'h0,        3'd2, 32'h8001AA44, 0, 3, 0));
        vecs.push_back(mk(0, 1, 32'h13,   32'hCAFEF00D, 3'd2, 32'h0,        MIS, MIS ? 1 : 3, 0));
        vecs.push_back(mk(0, 0, 32'h10,   32'h0,        3'd2, MIS ? 32'hDEADBEEF : 32'hCAFEF00D, 0, 3, 0));
        vecs.push_back(mk(0, 0, 32'h21,   32'h0,        3'd1, MIS ? 32'h0 : 32'hFFFFAA44, MIS, MIS ? 1 : 3, 0));
        vecs.push_back(mk(0, 0, 32'h1010, 32'h0,        3'd2, MIS ? 32'hDEADBEEF : 32'hCAFEF00D, 0, 3, 0));
        vecs.push_back(mk(0, 1, 32'h40,   32'h0,        3'd2, 32'h0,        0, 3, 0));
        vecs.push_back(mk(1, 1, 32'h1000, 32'h77,       3'd2, 32'h0,        0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,    32'h0,        3'd2, 32'h77,       0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,    32'h0,        3'd3, 32'h0,        1, 1, 0));
        vecs.push_back(mk(1, 1, 32'h1003, 32'h99,       3'd0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,    32'h0,        3'd2, 32'h99000077, 0, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0; #1;
        check("reset_a", {29'b0, o_ready, o_valid, o_err, o_rdata}, {29'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        sel = 1'b1; #1;
        check("reset_z", {29'b0, o_ready, o_valid, o_err, o_rdata}, {29'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while a store is waiting: the store to 0x40 must be abandoned.
        sel = 1'b0; #1;
        wait_idle("rst_seq");
        t_valid = 1'b1; t_write = 1'b1; t_addr = 32'h40; t_wdata = 32'h5; t_f3 = 3'd2;
        @(posedge clk); #1;
        t_valid = 1'b0;
        check("rst_in_wait", 64'(o_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("rst_async", {29'b0, o_ready, o_valid, o_err, o_rdata}, {29'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(100, mk(0, 0, 32'h40, 32'h0, 3'd2, 32'h0, 0, 3, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
